// File: rtl/timebase_pkg.sv
// Shared types and defaults for the timebase controller slice.
package timebase_pkg;

  localparam int unsigned CNT_W       = 26;
  localparam int unsigned DEFAULT_DIV = 25_000_000;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

endpackage

// File: rtl/timebase_controller_if.sv
// Divisor configuration port: valid/ready request carrying channel, divisor and enable.
interface timebase_controller_if #(
  parameter int unsigned CNT_W = 26
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_en;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready
  );

endinterface

// File: rtl/timebase_channel.sv
// One timebase channel: counter, active/shadow divisor, tick pulse and toggle.
module timebase_channel #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic             idle,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_en,
  output logic             tick,
  output logic             toggle,
  output logic             pending
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] div_shadow;
  logic             enable;
  logic             load_now;

  // A new divisor can take effect at once when the channel is not actively counting.
  assign load_now = idle || !enable || !load_en;

  // Counting, terminal-count handling and divisor loading.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      div_active <= CNT_W'(DEFAULT_DIV);
      div_shadow <= '0;
      pending    <= 1'b0;
      enable     <= 1'b1;
      tick       <= 1'b0;
      toggle     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear) begin
        count  <= '0;
        toggle <= 1'b0;
      end else if (run && enable) begin
        if (count == div_active) begin
          tick   <= 1'b1;
          toggle <= ~toggle;
          count  <= '0;
          if (pending) begin
            div_active <= div_shadow;
            pending    <= 1'b0;
          end
        end else begin
          count <= count + CNT_W'(1);
        end
      end
      if (load) begin
        enable <= load_en;
        if (load_now) begin
          div_active <= load_div;
          pending    <= 1'b0;
        end else begin
          div_shadow <= load_div;
          pending    <= 1'b1;
        end
        if (!load_en) begin
          count  <= '0;
          toggle <= 1'b0;
          tick   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/timebase_controller.sv
// Run/pause/stop sequencer and config decode for NUM_CH timebase channels.
module timebase_controller #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CNT_W       = timebase_pkg::CNT_W,
  parameter int unsigned DEFAULT_DIV = timebase_pkg::DEFAULT_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  stop,
  timebase_controller_if.slave  cfg,
  output logic [NUM_CH-1:0]     tick,
  output logic [NUM_CH-1:0]     toggle,
  output logic [1:0]            state
);

  import timebase_pkg::*;

  state_t            st_q;
  logic              idle;
  logic              run;
  logic              clear;
  logic              xfer;
  logic [NUM_CH-1:0] pending;
  logic [3:0]        pend_ext;

  assign state = st_q;
  assign idle  = (st_q == IDLE);
  // Channels count only while RUN persists across this edge, so no tick lands in HALT/IDLE.
  assign run   = (st_q == RUN) && !stop && !pause;
  assign clear = stop && !idle;

  // Sequencer with stop > pause > start priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE;
    end else begin
      case (st_q)
        IDLE: if (start && !stop) st_q <= RUN;
        RUN: begin
          if (stop)       st_q <= IDLE;
          else if (pause) st_q <= HALT;
        end
        HALT: begin
          if (stop)       st_q <= IDLE;
          else if (start) st_q <= RUN;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // Out-of-range channel indices see a zero pending bit and are always accepted.
  always_comb begin
    pend_ext               = '0;
    pend_ext[NUM_CH-1:0]   = pending;
  end

  assign cfg.cfg_ready = ~pend_ext[cfg.cfg_ch];
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timebase_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .clear    (clear),
      .idle     (idle),
      .load     (xfer && (cfg.cfg_ch == 2'(i))),
      .load_div (cfg.cfg_div),
      .load_en  (cfg.cfg_en),
      .tick     (tick[i]),
      .toggle   (toggle[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_timebase_controller.sv
// Scoreboard bench for timebase_controller with a small DEFAULT_DIV.
module tb_timebase_controller;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 26;
  localparam int unsigned DIV0   = 3;

  typedef struct packed {
    logic [1:0]        st;
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] tg;
  } exp_t;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              stop  = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] toggle;
  logic [1:0]        state;

  timebase_controller_if #(.CNT_W(CNT_W)) bus ();

  timebase_controller #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DIV0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .pause  (pause),
    .stop   (stop),
    .cfg    (bus.slave),
    .tick   (tick),
    .toggle (toggle),
    .state  (state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  exp_t sb[$];

  // Reference model state
  int m_st;
  int m_cnt  [NUM_CH];
  int m_div  [NUM_CH];
  int m_sh   [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_en   [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_tog  [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_div[i] = DIV0; m_sh[i] = 0;
      m_pend[i] = 0; m_en[i] = 1; m_tick[i] = 0; m_tog[i] = 0;
    end
  endtask

  function automatic bit model_ready();
    int idx;
    idx = int'(bus.cfg_ch);
    if (idx >= NUM_CH) return 1'b1;
    return !m_pend[idx];
  endfunction

  task automatic model_update();
    int nst;
    int c;
    bit xfer;
    xfer = bus.cfg_valid && model_ready();
    c    = int'(bus.cfg_ch);
    nst  = m_st;
    if (m_st == 0) begin
      if (start && !stop) nst = 1;
    end else if (stop) nst = 0;
    else if (m_st == 1 && pause) nst = 2;
    else if (m_st == 2 && start) nst = 1;
    for (int i = 0; i < NUM_CH; i++) begin
      m_tick[i] = 0;
      if (m_st != 0 && nst == 0) begin
        m_cnt[i] = 0; m_tog[i] = 0;
      end else if (m_st == 1 && nst == 1 && m_en[i]) begin
        if (m_cnt[i] == m_div[i]) begin
          m_tick[i] = 1; m_tog[i] = !m_tog[i]; m_cnt[i] = 0;
          if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 0; end
        end else m_cnt[i]++;
      end
      if (xfer && c == i) begin
        if (m_st == 0 || !m_en[i] || !bus.cfg_en) m_div[i] = int'(bus.cfg_div);
        else begin m_sh[i] = int'(bus.cfg_div); m_pend[i] = 1; end
        m_en[i] = bus.cfg_en;
        if (!bus.cfg_en) begin
          m_cnt[i] = 0; m_tog[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
        end
      end
    end
    m_st = nst;
  endtask

  // One clock: check ready, predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    #1;
    check("cfg_ready", 32'(bus.cfg_ready), 32'(model_ready()));
    model_update();
    e.st = 2'(m_st);
    for (int i = 0; i < NUM_CH; i++) begin
      e.tk[i] = m_tick[i];
      e.tg[i] = m_tog[i];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("state",  32'(state),  32'(e.st));
    check("tick",   32'(tick),   32'(e.tk));
    check("toggle", 32'(toggle), 32'(e.tg));
  endtask

  task automatic ctl(input bit s, input bit p, input bit t);
    start = s; pause = p; stop = t;
    step();
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic cfg(input int ch, input int div, input bit en);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_div   = CNT_W'(div);
    bus.cfg_en    = en;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n <= limit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    bit sv_tog;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = 2'd0;
    bus.cfg_div   = '0;
    bus.cfg_en    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",  32'(state),  32'd0);
    check("rst_tick",   32'(tick),   32'd0);
    check("rst_toggle", 32'(toggle), 32'd0);
    check("rst_ready",  32'(bus.cfg_ready), 32'd1);
    @(negedge clk) reset = 1'b1;

    // Idle, then run with the default divisor
    step();
    ctl(1, 0, 0);
    check("run_state", 32'(state), 32'd1);
    wait_tick(0, 8, n); check("first_tick", 32'(n), 32'd4);
    wait_tick(0, 8, n); check("period_def", 32'(n), 32'd4);

    // Mid-period divisor change on ch0 waits for the terminal count
    step();
    cfg(0, 1, 1);
    bus.cfg_ch = 2'd0;
    #1 check("ready_low", 32'(bus.cfg_ready), 32'd0);
    wait_tick(0, 8, n); check("old_period_end", 32'(n), 32'd2);
    #1 check("ready_back", 32'(bus.cfg_ready), 32'd1);
    wait_tick(0, 8, n); check("new_period_a", 32'(n), 32'd2);
    wait_tick(0, 8, n); check("new_period_b", 32'(n), 32'd2);

    // Pause two cycles into a ch2 period
    wait_tick(2, 8, n);
    step(); step();
    sv_tog = m_tog[2];
    ctl(0, 1, 0);
    check("halt_state", 32'(state), 32'd2);
    seen = 0;
    repeat (10) begin
      step();
      if (tick != '0) seen++;
    end
    check("halt_ticks", 32'(seen), 32'd0);
    check("halt_toggle", 32'(toggle[2]), 32'(sv_tog));
    ctl(1, 0, 0);
    wait_tick(2, 8, n); check("resume_tick", 32'(n), 32'd2);

    // Disable ch1, then re-enable at divisor 0
    cfg(1, 3, 0);
    check("dis_tick",   32'(tick[1]),   32'd0);
    check("dis_toggle", 32'(toggle[1]), 32'd0);
    repeat (3) step();
    cfg(1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      wait_tick(1, 4, n); check("div0_tick", 32'(n), 32'd1);
    end

    // Pending on ch2, then start+pause+stop together
    cfg(2, 5, 1);
    ctl(1, 1, 1);
    check("stop_state",  32'(state),  32'd0);
    check("stop_toggle", 32'(toggle), 32'd0);
    bus.cfg_ch = 2'd2;
    #1 check("pend_kept", 32'(bus.cfg_ready), 32'd0);
    cfg(3, 7, 0);
    step();
    ctl(1, 0, 0);
    wait_tick(2, 8, n);  check("restart_old", 32'(n), 32'd4);
    wait_tick(2, 10, n); check("shadow_applied", 32'(n), 32'd6);

    // Async reset mid-period with ch0 pending
    cfg(0, 2, 1);
    step();
    bus.cfg_ch = 2'd0;
    #2 reset = 1'b0;
    #1;
    check("arst_state",  32'(state),  32'd0);
    check("arst_tick",   32'(tick),   32'd0);
    check("arst_toggle", 32'(toggle), 32'd0);
    check("arst_ready",  32'(bus.cfg_ready), 32'd1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step();
    ctl(1, 0, 0);
    wait_tick(0, 8, n); check("post_rst_first",  32'(n), 32'd4);
    wait_tick(0, 8, n); check("post_rst_period", 32'(n), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/timebase_controller.md
Name: timebase_controller

Overview:
- Programmable timebase that sequences NUM_CH clock-enable channels from the single board clock.
- Each channel emits a one-cycle tick and a 50% duty toggle at a runtime-configurable rate.
- Replaces fixed dividers so consumers (display refresh, game step, debounce sampling) share one clock domain and one control point.
- A global run/pause/stop FSM gates all channels. Divisor updates arrive over a valid/ready config port and are applied glitch-free at the channel's terminal count.

Parameters:
NUM_CH, 3, number of independent timebase channels (1..4)
CNT_W, 26, counter/divisor width in bits
DEFAULT_DIV, 25000000, divisor loaded into every channel at reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level/pulse, request RUN
pause  in  1  level/pulse, request HALT
stop  in  1  level/pulse, request IDLE
cfg_valid  in  1  config request valid
cfg_ready  out  1  config request accepted when high with cfg_valid
cfg_ch  in  2  target channel index
cfg_div  in  CNT_W  new divisor (terminal count)
cfg_en  in  1  new channel enable
tick  out  NUM_CH  one-cycle pulse per channel at terminal count
toggle  out  NUM_CH  square wave per channel, flips at each tick
state  out  2  00 IDLE, 01 RUN, 10 HALT

Behaviour:
- Reset asserted (reset=0), asynchronous: state=IDLE; all counters 0; tick=0; toggle=0; div_active=DEFAULT_DIV; enable=1 for all channels; pending=0; cfg_ready=1.
- FSM, evaluated each posedge, priority stop > pause > start:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE; pause -> HALT.
  - HALT: stop -> IDLE; start -> RUN.
- Entering IDLE clears all counters and toggles. HALT freezes counters and toggles. No ticks in IDLE or HALT.
- Channel in RUN with enable=1, per cycle:
  - count==div_active: tick=1 that cycle (registered, visible the following cycle), toggle flips, count<=0. If pending, div_active<=div_shadow and pending<=0.
  - otherwise count<=count+1, tick=0.
  - Tick period = div_active+1 cycles; toggle period = 2*(div_active+1).
  - div_active=0 gives a tick every cycle and toggle at clk/2.
- The first tick after IDLE->RUN is registered div_active+1 cycles after the RUN state is entered.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch], combinational from registers.
  - Transfer occurs on cfg_valid && cfg_ready.
  - cfg_ch >= NUM_CH: the transfer is accepted and ignored (cfg_ready=1).
- On transfer, enable[ch]<=cfg_en, plus one of:
  - state==IDLE, or channel currently disabled, or cfg_en=0: div_active<=cfg_div immediately; pending not set.
  - otherwise: div_shadow<=cfg_div, pending<=1; applied at the next terminal count.
- Disabling a channel (cfg_en=0) clears its count and toggle that cycle and drops pending. It produces no tick.
- A transfer in the same cycle as the terminal count with pending=0: the terminal count uses the old div_active and the new value becomes pending. It is applied at the following terminal count.
- stop while pending=1: pending is kept; the shadow value is applied at the first terminal count after restart.
- Counter comparison is equality on CNT_W bits, unsigned. A divisor reduced below the current count cannot occur because updates only apply at count==0.
- reset asserted mid-operation returns everything to the reset values immediately. No tick is issued on reset release.

Decomposition:
- Shared package timebase_pkg:
  - state_t enum (IDLE, RUN, HALT).
  - constant DEFAULT_DIV.
  - CNT_W typedef cnt_t.
- Sub-module timebase_channel, instantiated NUM_CH times. It holds count, div_active, div_shadow, pending, enable, tick and toggle. Inputs are run, clear and a load interface.
- The top level holds the FSM, the config decode and cfg_ready.

Test Plan:
- DEFAULT_DIV=3, reset, start -> state=01; each channel tick every 4 cycles; toggle high for 4, low for 4; first tick 4 cycles after RUN.
- In RUN, cfg ch0 div=1 mid-period -> cfg_ready[ch0] drops for the next request; the current period finishes at 4 cycles, then ticks every 2 cycles; cfg_ready returns high.
- pause after 2 cycles of a period, hold 10 cycles, start -> no ticks during HALT; next tick 2 cycles after resume; toggle level unchanged across HALT.
- cfg ch1 en=0 in RUN -> tick[1]=0 and toggle[1]=0 at once. Re-enable with div=0 -> tick[1] every cycle and toggle[1] at clk/2.
- start, pause and stop asserted in the same cycle from RUN -> state=IDLE, counters and toggles 0. cfg_ch=3 with NUM_CH=3 -> accepted, no channel changes.
- Pull reset low mid-period with pending set -> all outputs 0 and state=IDLE asynchronously. Release reset, start -> ticks at DEFAULT_DIV+1 spacing; pending is gone.
